// File: rtl/wb_write_buffer.sv
// -----------------------------------------------------------------------------
// wb_write_buffer
//
// Buffered write-back unit between the execute stage and the 16 x 16-bit
// register file. Results arrive over a valid/ready handshake, queue in a
// small FIFO and retire into the register file write port at one write per
// cycle. Pending writes are optionally bypassed onto the two read ports.
//
// Build option:
//   WB_FWD_EN  defined   -> read data is bypassed from pending writes
//              undefined -> fwd_outN = rf_outN (no comparators); upstream
//                           uses count to stall on hazards
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     result handshake from execute
//   in_dest, in_data      destination register and result value
//   rf_hold               suppresses retirement in the current cycle
//   RegWrite, select3,    registered register-file write port
//   WriteData
//   select1, select2      read selects (shared with the register file)
//   rf_out1, rf_out2      register-file read data
//   fwd_out1, fwd_out2    read data with pending writes bypassed
//   count                 registered FIFO occupancy
// -----------------------------------------------------------------------------
module wb_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_dest,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     rf_hold,
   output logic                     RegWrite,
   output logic [ADDR_W-1:0]        select3,
   output logic [DATA_W-1:0]        WriteData,
   input  logic [ADDR_W-1:0]        select1,
   input  logic [ADDR_W-1:0]        select2,
   input  logic [DATA_W-1:0]        rf_out1,
   input  logic [DATA_W-1:0]        rf_out2,
   output logic [DATA_W-1:0]        fwd_out1,
   output logic [DATA_W-1:0]        fwd_out2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

   // FIFO storage and bookkeeping
   logic [ADDR_W-1:0] dest_mem_r [DEPTH];
   logic [DATA_W-1:0] data_mem_r [DEPTH];
   logic [PTR_W-1:0]  head_r;
   logic [PTR_W-1:0]  tail_r;
   logic [CNT_W-1:0]  count_r;

   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic [CNT_W-1:0]  count_nxt_s;

   // Full is decoded from the registered count only, so a full buffer
   // refuses input even in a cycle where it also retires an entry.
   assign full_s   = (count_r == DEPTH_C);
   assign in_ready = ~full_s;
   assign push_s   = in_valid & ~full_s;
   assign pop_s    = (count_r != CNT_ZERO) & ~rf_hold;
   assign count    = count_r;

   // Next occupancy: simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Occupancy and pointer registers; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= CNT_ZERO;
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
      end else begin
         count_r <= count_nxt_s;
         if (push_s) begin
            tail_r <= tail_r + PTR_ONE;
         end
         if (pop_s) begin
            head_r <= head_r + PTR_ONE;
         end
      end
   end

   // Entry storage: written only on accepting edges, never reset because
   // occupancy alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push_s) begin
         dest_mem_r[tail_r] <= in_dest;
         data_mem_r[tail_r] <= in_data;
      end
   end

   // Register-file write port: pulse RegWrite for each retired entry and
   // keep the last address/data otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite  <= 1'b0;
         select3   <= {ADDR_W{1'b0}};
         WriteData <= {DATA_W{1'b0}};
      end else begin
         RegWrite <= pop_s;
         if (pop_s) begin
            select3   <= dest_mem_r[head_r];
            WriteData <= data_mem_r[head_r];
         end
      end
   end

`ifdef WB_FWD_EN
   // Youngest-wins lookup: seed with the output register (its write commits
   // at the next edge), then walk the FIFO from oldest to youngest so that
   // younger matches override older ones.
   function automatic logic [DATA_W-1:0] fwd_lookup(
      input logic [ADDR_W-1:0] sel,
      input logic [DATA_W-1:0] rf_data
   );
      logic [DATA_W-1:0] res;
      logic [PTR_W-1:0]  idx;
      if (RegWrite && (select3 == sel)) begin
         res = WriteData;
      end else begin
         res = rf_data;
      end
      for (int j = 0; j < DEPTH; j++) begin
         idx = head_r + PTR_W'(j);
         if ((CNT_W'(j) < count_r) && (dest_mem_r[idx] == sel)) begin
            res = data_mem_r[idx];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Read port 1 bypass.
   always_comb begin
      fwd_out1 = rf_out1;
      fwd_out1 = fwd_lookup(select1, rf_out1);
   end

   // Read port 2 bypass.
   always_comb begin
      fwd_out2 = rf_out2;
      fwd_out2 = fwd_lookup(select2, rf_out2);
   end
`else
   // Read selects only steer the register file itself in this build.
   logic unused_sel_s;
   assign unused_sel_s = ^{select1, select2};

   // No bypass: read data passes straight through.
   always_comb begin
      fwd_out1 = rf_out1;
      fwd_out2 = rf_out2;
   end
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_write_buffer
//
// Self-checking bench for wb_write_buffer: a table of per-edge vectors
// (inputs applied before the edge, outputs compared 1 ns after it) plus
// hand-written sequences for the same-register hazard and mid-run reset.
// Forwarding expectations follow the WB_FWD_EN build option.
// -----------------------------------------------------------------------------
module tb_wb_write_buffer;

`ifdef WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_dest;
   logic [15:0] in_data;
   logic        rf_hold;
   logic        RegWrite;
   logic [3:0]  select3;
   logic [15:0] WriteData;
   logic [3:0]  select1;
   logic [3:0]  select2;
   logic [15:0] rf_out1;
   logic [15:0] rf_out2;
   logic [15:0] fwd_out1;
   logic [15:0] fwd_out2;
   logic [2:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   wb_write_buffer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_dest(in_dest), .in_data(in_data),
      .rf_hold(rf_hold),
      .RegWrite(RegWrite), .select3(select3), .WriteData(WriteData),
      .select1(select1), .select2(select2),
      .rf_out1(rf_out1), .rf_out2(rf_out2),
      .fwd_out1(fwd_out1), .fwd_out2(fwd_out2),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [3:0]  dest;
      logic [15:0] data;
      logic        hold;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [15:0] r1;
      logic [15:0] r2;
      logic        e_rdy;
      logic        e_rw;
      logic [3:0]  e_s3;
      logic [15:0] e_wd;
      logic [2:0]  e_cnt;
      logic [15:0] e_f1;
      logic [15:0] e_f2;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(
      input logic rs, input logic v, input logic [3:0] d, input logic [15:0] dt,
      input logic h, input logic [3:0] a1, input logic [3:0] a2,
      input logic [15:0] q1, input logic [15:0] q2,
      input logic rdy, input logic rw, input logic [3:0] s3, input logic [15:0] wd,
      input logic [2:0] cnt, input logic [15:0] f1, input logic [15:0] f2);
      vec_t t;
      t.rst = rs; t.vld = v; t.dest = d; t.data = dt; t.hold = h;
      t.s1 = a1; t.s2 = a2; t.r1 = q1; t.r2 = q2;
      t.e_rdy = rdy; t.e_rw = rw; t.e_s3 = s3; t.e_wd = wd;
      t.e_cnt = cnt; t.e_f1 = f1; t.e_f2 = f2;
      return t;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rs, input logic v, input logic [3:0] d,
                        input logic [15:0] dt, input logic h);
      rst = rs; in_valid = v; in_dest = d; in_data = dt; rf_hold = h;
   endtask

   logic [15:0] pulses[$];
   logic [15:0] exp_f;
   int          nrw;

   initial begin
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
      select1 = 4'd0; select2 = 4'd0; rf_out1 = 16'h1111; rf_out2 = 16'h2222;

      //            rst  vld  dest   data      hold  s1    s2    r1        r2          rdy  rw   s3     wd        cnt   f1        f2
      vecs[0]  = mk(1'b1,1'b0,4'd0, 16'h0000,1'b0, 4'd0, 4'd3, 16'h1111,16'h2222,  1'b1,1'b0,4'd0, 16'h0000,3'd0, 16'h1111,16'h2222);
      vecs[1]  = mk(1'b0,1'b1,4'd5, 16'h35A5,1'b0, 4'd5, 4'd3, 16'h1111,16'h2222,  1'b1,1'b0,4'd0, 16'h0000,3'd1, 16'h35A5,16'h2222);
      vecs[2]  = mk(1'b0,1'b0,4'd15,16'hDEAD,1'b0, 4'd5, 4'd3, 16'h1111,16'h2222,  1'b1,1'b1,4'd5, 16'h35A5,3'd0, 16'h35A5,16'h2222);
      vecs[3]  = mk(1'b0,1'b0,4'd0, 16'h0000,1'b0, 4'd5, 4'd3, 16'h1111,16'h2222,  1'b1,1'b0,4'd5, 16'h35A5,3'd0, 16'h1111,16'h2222);
      vecs[4]  = mk(1'b0,1'b0,4'd0, 16'h0000,1'b0, 4'd9, 4'd3, 16'h1234,16'h2222,  1'b1,1'b0,4'd5, 16'h35A5,3'd0, 16'h1234,16'h2222);
      vecs[5]  = mk(1'b0,1'b1,4'd1, 16'h0001,1'b1, 4'd1, 4'd4, 16'h1111,16'h2222,  1'b1,1'b0,4'd5, 16'h35A5,3'd1, 16'h0001,16'h2222);
      vecs[6]  = mk(1'b0,1'b1,4'd2, 16'h0002,1'b1, 4'd1, 4'd4, 16'h1111,16'h2222,  1'b1,1'b0,4'd5, 16'h35A5,3'd2, 16'h0001,16'h2222);
      vecs[7]  = mk(1'b0,1'b1,4'd3, 16'h0003,1'b1, 4'd1, 4'd4, 16'h1111,16'h2222,  1'b1,1'b0,4'd5, 16'h35A5,3'd3, 16'h0001,16'h2222);
      vecs[8]  = mk(1'b0,1'b1,4'd4, 16'h0004,1'b1, 4'd1, 4'd4, 16'h1111,16'h2222,  1'b0,1'b0,4'd5, 16'h35A5,3'd4, 16'h0001,16'h0004);
      vecs[9]  = mk(1'b0,1'b1,4'd6, 16'h0006,1'b1, 4'd6, 4'd4, 16'h1111,16'h2222,  1'b0,1'b0,4'd5, 16'h35A5,3'd4, 16'h1111,16'h0004);
      vecs[10] = mk(1'b0,1'b1,4'd6, 16'h0006,1'b0, 4'd6, 4'd1, 16'h1111,16'h2222,  1'b1,1'b1,4'd1, 16'h0001,3'd3, 16'h1111,16'h0001);
      vecs[11] = mk(1'b0,1'b0,4'd0, 16'h0000,1'b0, 4'd1, 4'd4, 16'h1111,16'h2222,  1'b1,1'b1,4'd2, 16'h0002,3'd2, 16'h1111,16'h0004);
      vecs[12] = mk(1'b0,1'b0,4'd0, 16'h0000,1'b0, 4'd3, 4'd4, 16'h1111,16'h2222,  1'b1,1'b1,4'd3, 16'h0003,3'd1, 16'h0003,16'h0004);
      vecs[13] = mk(1'b0,1'b0,4'd0, 16'h0000,1'b0, 4'd4, 4'd4, 16'h1111,16'h2222,  1'b1,1'b1,4'd4, 16'h0004,3'd0, 16'h0004,16'h0004);
      vecs[14] = mk(1'b0,1'b0,4'd0, 16'h0000,1'b0, 4'd4, 4'd4, 16'h1111,16'h2222,  1'b1,1'b0,4'd4, 16'h0004,3'd0, 16'h1111,16'h2222);
      vecs[15] = mk(1'b0,1'b1,4'd8, 16'h00A1,1'b0, 4'd8, 4'd8, 16'h1111,16'h2222,  1'b1,1'b0,4'd4, 16'h0004,3'd1, 16'h00A1,16'h00A1);
      vecs[16] = mk(1'b0,1'b1,4'd8, 16'h00B2,1'b0, 4'd8, 4'd8, 16'h1111,16'h2222,  1'b1,1'b1,4'd8, 16'h00A1,3'd1, 16'h00B2,16'h00B2);
      vecs[17] = mk(1'b0,1'b0,4'd0, 16'h0000,1'b0, 4'd8, 4'd8, 16'h1111,16'h2222,  1'b1,1'b1,4'd8, 16'h00B2,3'd0, 16'h00B2,16'h00B2);
      vecs[18] = mk(1'b0,1'b0,4'd0, 16'h0000,1'b0, 4'd8, 4'd8, 16'h1111,16'h2222,  1'b1,1'b0,4'd8, 16'h00B2,3'd0, 16'h1111,16'h2222);

      #2;
      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].rst, vecs[i].vld, vecs[i].dest, vecs[i].data, vecs[i].hold);
         select1 = vecs[i].s1; select2 = vecs[i].s2;
         rf_out1 = vecs[i].r1; rf_out2 = vecs[i].r2;
         step();
         check($sformatf("v%0d in_ready", i),  {31'd0, in_ready},   {31'd0, vecs[i].e_rdy});
         check($sformatf("v%0d RegWrite", i),  {31'd0, RegWrite},   {31'd0, vecs[i].e_rw});
         check($sformatf("v%0d select3", i),   {28'd0, select3},    {28'd0, vecs[i].e_s3});
         check($sformatf("v%0d WriteData", i), {16'd0, WriteData},  {16'd0, vecs[i].e_wd});
         check($sformatf("v%0d count", i),     {29'd0, count},      {29'd0, vecs[i].e_cnt});
         exp_f = FWD ? vecs[i].e_f1 : vecs[i].r1;
         check($sformatf("v%0d fwd_out1", i),  {16'd0, fwd_out1},   {16'd0, exp_f});
         exp_f = FWD ? vecs[i].e_f2 : vecs[i].r2;
         check($sformatf("v%0d fwd_out2", i),  {16'd0, fwd_out2},   {16'd0, exp_f});
      end

      // Same-register hazard held in the FIFO, then drained in order.
      select1 = 4'd0; select2 = 4'd7; rf_out1 = 16'h1111; rf_out2 = 16'h2222;
      drive(1'b0, 1'b1, 4'd7, 16'hAAAA, 1'b1); step();
      drive(1'b0, 1'b1, 4'd7, 16'hBBBB, 1'b1); step();
      drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1); step();
      check("hz count", {29'd0, count}, 32'd2);
      exp_f = FWD ? 16'hBBBB : 16'h2222;
      check("hz fwd_out2", {16'd0, fwd_out2}, {16'd0, exp_f});
      pulses.delete();
      drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
      for (int c = 0; c < 6; c++) begin
         step();
         if (RegWrite) begin
            pulses.push_back(WriteData);
            check("hz select3", {28'd0, select3}, 32'd7);
         end
      end
      check("hz pulses", pulses.size(), 32'd2);
      if (pulses.size() == 2) begin
         check("hz first", {16'd0, pulses[0]}, 32'h0000AAAA);
         check("hz second", {16'd0, pulses[1]}, 32'h0000BBBB);
      end

      // Reset with three queued writes discards them all.
      drive(1'b0, 1'b1, 4'd10, 16'h0A0A, 1'b1); step();
      drive(1'b0, 1'b1, 4'd11, 16'h0B0B, 1'b1); step();
      drive(1'b0, 1'b1, 4'd12, 16'h0C0C, 1'b1); step();
      check("rs count before", {29'd0, count}, 32'd3);
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0); step();
      check("rs count", {29'd0, count}, 32'd0);
      check("rs RegWrite", {31'd0, RegWrite}, 32'd0);
      check("rs select3", {28'd0, select3}, 32'd0);
      check("rs WriteData", {16'd0, WriteData}, 32'd0);
      drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
      nrw = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (RegWrite) nrw++;
      end
      check("rs stale writes", nrw, 32'd0);
      check("rs in_ready", {31'd0, in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_write_buffer.md
# wb_write_buffer

Buffered write-back unit that drives the register file's write port (write select, write data, write enable) and bypasses pending writes to the register file's two read ports. The execute stage hands results in over a valid/ready handshake. Results queue in a small FIFO and retire into the register file at one write per cycle. The block sits between the execute stage and the 16 x 16-bit register file, and is the writer counterpart of that file.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2
- DATA_W, 16, register width
- ADDR_W, 4, register select width (16 registers)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  result available from execute
- in_ready  out  1  buffer can accept a result
- in_dest  in  ADDR_W  destination register
- in_data  in  DATA_W  result value
- rf_hold  in  1  suppresses retirement this cycle
- RegWrite  out  1  register file write enable (registered)
- select3  out  ADDR_W  register file write select (registered)
- WriteData  out  DATA_W  register file write data (registered)
- select1, select2  in  ADDR_W  read selects, also presented to the register file
- rf_out1, rf_out2  in  DATA_W  register file read data
- fwd_out1, fwd_out2  out  DATA_W  read data with pending writes bypassed
- count  out  clog2(DEPTH)+1  FIFO occupancy (registered)

## Operation
- Enqueue: on an edge with in_valid and in_ready, {in_dest, in_data} is written at the tail and count increments.
- in_ready is !full, decoded combinationally from the registered count. A full buffer refuses input even in a cycle where it retires an entry.
- Retire: on each edge with count > 0 and rf_hold = 0, the head entry is popped into select3/WriteData and RegWrite = 1.
- On any other edge, RegWrite = 0, and select3/WriteData hold their last values.
- Simultaneous enqueue and retire leaves count unchanged. Pointers wrap modulo DEPTH.
- Ordering is strict FIFO. Writes to the same register are not coalescing: each accepted result produces exactly one RegWrite pulse, in acceptance order.
- Pending set: all FIFO entries, plus the output register while RegWrite = 1 (its write commits at the next edge).
- Forwarding, evaluated combinationally per read port:
  - fwd_outN = data of the youngest pending entry whose destination equals selectN.
  - If no pending entry matches, fwd_outN = rf_outN.
  - Priority is youngest FIFO entry, then older FIFO entries, then the output register.
- An entry on the in_* bus in the same cycle is not yet pending and is not forwarded.
- Register 0 receives no special treatment.

## Timing
- Reset state, at the edge with rst high: count = 0, FIFO contents invalid, RegWrite = 0, select3 = 0, WriteData = 0. in_ready = 1 from the following cycle.
- Reset mid-operation discards all queued and in-flight writes. No RegWrite pulse follows the reset edge.
- Latency, empty buffer: result accepted at edge k; RegWrite high after edge k+1; register file commits at edge k+2. The value is forwarded from the cycle after edge k onward.
- Throughput: one retirement per cycle while rf_hold = 0. A back-to-back stream of accepted results never raises count above 1.
- rf_hold asserted before edge k: no pop at edge k, and RegWrite = 0 after it. Retirement resumes on the first edge with rf_hold = 0.
- Full: count = DEPTH forces in_ready = 0. in_ready returns to 1 the cycle after the first retirement.
- in_dest/in_data are sampled only on accepting edges. Inputs while in_valid = 0 are ignored.

## Configuration
- Macro WB_FWD_EN.
- Defined: forwarding as described above.
- Undefined: fwd_out1 = rf_out1 and fwd_out2 = rf_out2, with no comparators. Upstream then stalls on hazards, for which count is provided. Queueing and retirement are identical in both builds.

## Test plan
- Reset, then accept {dest 5, 16'h35A5} at edge k: RegWrite = 1 with select3 = 5 and WriteData = 16'h35A5 after edge k+1, for exactly one cycle. fwd_out1 = 16'h35A5 with select1 = 5 from the cycle after edge k.
- rf_hold high: accept {1,16'h0001}, {2,16'h0002}, {3,16'h0003}, {4,16'h0004} -> count = 4 and in_ready = 0; a 5th valid is refused. Release rf_hold -> four RegWrite pulses in order 1, 2, 3, 4, and in_ready = 1 after the first.
- Same-register hazard, rf_hold high: enqueue {7,16'hAAAA} then {7,16'hBBBB} -> fwd_out2 = 16'hBBBB with select2 = 7. Release rf_hold -> pulses 16'hAAAA then 16'hBBBB.
- No pending match: select1 = 9 with rf_out1 = 16'h1234 -> fwd_out1 = 16'h1234.
- Reset with count = 3 -> count = 0 and RegWrite = 0 after the reset edge; no stale writes afterward.
- Build without WB_FWD_EN: repeat the hazard scenario -> fwd_out2 = rf_out2; the retirement order is unchanged.
